uart_rx_fifo: RTL and testbench

UART receive front-end with a buffered byte stream output. It oversamples the RX pin on the system clock and deserialises 8N1 frames. Good bytes are pushed into an internal synchronous FIFO, which Data_Transmit drains through a valid/ready handshake. It sits between the top-level RX pin and the transmit path, on the clk_wiz output clock and the processed reset from rstpulse.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Integer baud divisor; truncation is intentional (434 at 50 MHz / 115200).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with binary pointers carrying an extra wrap bit.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Aw    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      count_o,
  output logic             overflow_o
);

  localparam int unsigned Depth = 2 ** Aw;

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wr_ptr_q, wr_ptr_d;
  logic [Aw:0]      rd_ptr_q, rd_ptr_d;
  logic             pop_ok, push_ok;

  // Status, handshake qualification and head-of-queue view.
  always_comb begin
    empty_o    = (wr_ptr_q == rd_ptr_q);
    full_o     = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
    pop_ok     = pop_i && !empty_o;
    push_ok    = push_i && (!full_o || pop_ok);
    overflow_o = push_i && !push_ok;
    count_o    = wr_ptr_q - rd_ptr_q;
    // Drive zero when empty so the output never shows stale storage.
    rdata_o    = empty_o ? '0 : mem_q[rd_ptr_q[Aw-1:0]];
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; a full-FIFO push with pop reuses the slot being read out this cycle.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[Aw-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a FWFT byte FIFO.
// The RX line is double-flopped, then a mid-bit sampling FSM deserialises frames and pushes
// good bytes; bad frames raise a one-cycle error pulse in the stop-sample cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [7:0]         m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               frame_err,
`ifdef UART_RX_PARITY_EN
  output logic               parity_err,
`endif
  output logic               overflow
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam logic [CntW-1:0] CntBitEnd = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf   = CntW'(ClksPerBit / 2 - 1);
  localparam logic [2:0]      LastBit   = 3'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push, fe_raw;
  logic                 fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 pe_raw;
`endif

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM next-state: mid-bit sampling off the baud counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    fe_raw    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    pe_raw    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          // A start bit that has gone high by mid-bit was a glitch.
          if (!rx_s_q) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntBitEnd) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == CntBitEnd) begin
          cnt_d     = '0;
          par_bit_d = rx_s_q;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (cnt_q == CntBitEnd) begin
          // Leave mid-stop-bit so the next start edge is caught early.
          state_d = StIdle;
          cnt_d   = '0;
          if (!rx_s_q) begin
            fe_raw = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bit_q != ^shift_q) begin
            pe_raw = 1'b1;
`endif
          end else begin
            push = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // Error pulses are suppressed while reset is asserted.
  always_comb begin
    frame_err = fe_raw && !rst;
`ifdef UART_RX_PARITY_EN
    parity_err = pe_raw && !rst;
`endif
  end

  sync_fifo #(
    .Width (DATA_BITS),
    .Aw    (FIFO_AW)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push && !rst),
    .wdata_i    (shift_q),
    .pop_i      (m_ready),
    .rdata_o    (m_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .overflow_o (overflow)
  );

  assign m_valid = !fifo_empty;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scenario bench for uart_rx_fifo: a reduced clock (43 clocks per bit) keeps runtime short.
// Expected bytes go into a scoreboard queue as frames are sent and are compared on drain.
module tb_uart_rx_fifo;

  localparam int unsigned ClkFreq = 5000000;
  localparam int unsigned Baud    = 115200;
  localparam int unsigned Aw      = 4;
  localparam int          Cpb     = ClkFreq / Baud;
  localparam int          Half    = Cpb / 2;
  localparam int          Depth   = 2 ** Aw;
  // rx falls just after edge 0: 2 sync flops + 1 IDLE cycle, half bit, 8 data bits,
  // then a full bit into STOP; the push edge is this many edges later.
  localparam int          PushLat = 3 + Half + 9 * Cpb;

  logic         clk, rst, rx, m_ready;
  logic [7:0]   m_data;
  logic         m_valid, frame_err, overflow;
  logic [Aw:0]  fifo_count;
`ifdef UART_RX_PARITY_EN
  logic         parity_err;
`endif

  uart_rx_fifo #(
    .CLK_FREQ  (ClkFreq),
    .BAUD_RATE (Baud),
    .FIFO_AW   (Aw)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fe_cnt = 0, ovf_cnt = 0, fe_cyc = -1, ovf_cyc = -1, rise_cyc = -1;
  int         start_cyc = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and edge monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    if (overflow) begin
      ovf_cnt = ovf_cnt + 1;
      ovf_cyc = cyc;
    end
    if (m_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = m_valid;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Drive one frame; a bad stop bit is held low most of the bit, then released.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (Cpb) @(posedge clk);
      #1 rx = data[i];
    end
    repeat (Cpb) @(posedge clk);
    #1 rx = stop_bit;
    if (stop_bit) begin
      repeat (Cpb) @(posedge clk);
    end else begin
      repeat (Cpb - 10) @(posedge clk);
      #1 rx = 1'b1;
      repeat (10) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    int fe0, ovf0, bad;
    rst = 1'b1;
    rx = 1'b1;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", m_valid); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %0b expected 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b expected 0", overflow); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h expected 0", m_data); end
    rst = 1'b0;
    fe0 = fe_cnt;
    ovf0 = ovf_cnt;
    bad = 0;
    repeat (10 * Cpb) begin
      @(posedge clk);
      #1;
      if (m_valid !== 1'b0 || fifo_count !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL idle_ferr: got %0d expected %0d", fe_cnt, fe0); end
    checks++; if (ovf_cnt != ovf0) begin errors++; $display("FAIL idle_ovf: got %0d expected %0d", ovf_cnt, ovf0); end
  endtask

  task automatic test_single_byte();
    int fe0, bad;
    logic [7:0] exp_b;
    fe0 = fe_cnt;
    m_ready = 1'b0;
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    #1;
    checks++; if (rise_cyc - start_cyc != PushLat) begin errors++; $display("FAIL a5_latency: got %0d expected %0d", rise_cyc - start_cyc, PushLat); end
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL a5_count: got %0d expected 1", fifo_count); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL a5_ferr: got %0d expected %0d", fe_cnt, fe0); end
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (m_data !== 8'hA5 || m_valid !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL a5_stable: got %0d unstable cycles expected 0", bad); end
    exp_b = exp_q.pop_front();
    checks++; if (m_data !== exp_b) begin errors++; $display("FAIL a5_data: got %0h expected %0h", m_data, exp_b); end
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL a5_popped_valid: got %0b expected 0", m_valid); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL a5_popped_count: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx = 1'b1;
    repeat (12 * Cpb) @(posedge clk);
    #1;
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", fifo_count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %0b expected 0", m_valid); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_ferr: got %0d expected %0d", fe_cnt, fe0); end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (2 * Cpb) @(posedge clk);
    #1;
    checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL ferr_count: got %0d expected %0d", fe_cnt, fe0 + 1); end
    checks++; if (fe_cyc - start_cyc != PushLat - 1) begin errors++; $display("FAIL ferr_cycle: got %0d expected %0d", fe_cyc - start_cyc, PushLat - 1); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL ferr_fifo: got %0d expected 0", fifo_count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %0b expected 0", m_valid); end
  endtask

  task automatic test_overflow();
    int ovf0, ovf_start;
    logic [7:0] exp_b;
    ovf0 = ovf_cnt;
    ovf_start = 0;
    m_ready = 1'b0;
    for (int b = 0; b <= Depth; b++) begin
      send_frame(8'(b), 1'b1);
      if (b < Depth) exp_q.push_back(8'(b));
      else ovf_start = start_cyc;
    end
    @(posedge clk);
    #1;
    checks++; if (fifo_count !== 5'(Depth)) begin errors++; $display("FAIL ovf_full_count: got %0d expected %0d", fifo_count, Depth); end
    checks++; if (ovf_cnt != ovf0 + 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected %0d", ovf_cnt, ovf0 + 1); end
    checks++; if (ovf_cyc - ovf_start != PushLat - 1) begin errors++; $display("FAIL ovf_cycle: got %0d expected %0d", ovf_cyc - ovf_start, PushLat - 1); end
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid: got %0b expected 1", m_valid); end
      checks++; if (m_data !== exp_b) begin errors++; $display("FAIL ovf_drain_data: got %0h expected %0h", m_data, exp_b); end
      m_ready = 1'b1;
      @(posedge clk);
      #1 m_ready = 1'b0;
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b expected 0", m_valid); end
  endtask

  task automatic test_full_push_pop();
    int ovf0;
    logic [7:0] exp_b;
    m_ready = 1'b0;
    for (int b = 0; b < Depth; b++) begin
      send_frame(8'h20 + 8'(b), 1'b1);
      exp_q.push_back(8'h20 + 8'(b));
    end
    ovf0 = ovf_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        // Land the single pop exactly in the stop-sample cycle.
        repeat (PushLat) @(posedge clk);
        #1 m_ready = 1'b1;
        exp_b = exp_q.pop_front();
        checks++; if (m_data !== exp_b) begin errors++; $display("FAIL fp_pop_data: got %0h expected %0h", m_data, exp_b); end
        @(posedge clk);
        #1 m_ready = 1'b0;
      end
    join
    exp_q.push_back(8'h55);
    @(posedge clk);
    #1;
    checks++; if (fifo_count !== 5'(Depth)) begin errors++; $display("FAIL fp_count: got %0d expected %0d", fifo_count, Depth); end
    checks++; if (ovf_cnt != ovf0) begin errors++; $display("FAIL fp_ovf: got %0d expected %0d", ovf_cnt, ovf0); end
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL fp_drain_valid: got %0b expected 1", m_valid); end
      checks++; if (m_data !== exp_b) begin errors++; $display("FAIL fp_drain_data: got %0h expected %0h", m_data, exp_b); end
      m_ready = 1'b1;
      @(posedge clk);
      #1 m_ready = 1'b0;
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fp_empty: got %0b expected 0", m_valid); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    @(posedge clk);
    #1;
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL rm_pre_count: got %0d expected 1", fifo_count); end
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4 * Cpb) @(posedge clk);
    #1;
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12 * Cpb) @(posedge clk);
    #1;
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rm_count: got %0d expected 0", fifo_count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %0b expected 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rm_data: got %0h expected 0", m_data); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL rm_ferr: got %0d expected %0d", fe_cnt, fe0); end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    m_ready = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
